// File: rtl/sprite_motion_ctrl.sv
// sprite_motion_ctrl: once-per-frame bouncing sprite position update, applied during vertical blanking
module sprite_motion_ctrl #(
   parameter int SPRITE_WIDTH  = 128,
   parameter int SPRITE_HEIGHT = 128,
   parameter int ACTIVE_W      = 640,
   parameter int ACTIVE_H      = 480,
   parameter int SCREEN_WIDTH  = 800,
   parameter int SCREEN_HEIGHT = 525,
   parameter int START_X       = 0,
   parameter int START_Y       = 0,
   localparam int HW = $clog2(SCREEN_WIDTH),
   localparam int VW = $clog2(SCREEN_HEIGHT)
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic [HW-1:0] i_hcount,
   input  logic [VW-1:0] i_vcount,
   input  logic          i_enable,
   input  logic [3:0]    i_speed,
   output logic [HW-1:0] o_x,
   output logic [VW-1:0] o_y,
   output logic          o_dir_x,
   output logic          o_dir_y,
   output logic          o_bounce_x,
   output logic          o_bounce_y,
   output logic          o_busy
);
   localparam int MAXX = ACTIVE_W - SPRITE_WIDTH;
   localparam int MAXY = ACTIVE_H - SPRITE_HEIGHT;
   if (SPRITE_WIDTH >= ACTIVE_W || SPRITE_HEIGHT >= ACTIVE_H || START_X > MAXX || START_Y > MAXY) begin : g_bad_params
      $error("sprite_motion_ctrl: sprite size or start position does not fit the active area");
   end
   typedef enum logic [2:0] {IDLE, RUN, UPD_X, UPD_Y, PAUSE} state_t;
   state_t        r_state;
   logic          r_raw_q;
   logic [3:0]    r_speed;
   logic          w_raw, w_tick;
   logic [HW:0]   w_nx;
   logic [VW:0]   w_ny;
   logic          w_hit_x, w_hit_y;
   logic [HW-1:0] w_x_next;
   logic [VW-1:0] w_y_next;
   assign w_raw  = i_hcount == HW'(ACTIVE_W) && i_vcount == VW'(ACTIVE_H);
   assign w_tick = w_raw && !r_raw_q;
   // x uses the live speed (sampled in UPD_X); y reuses that sample so both axes agree
   assign w_nx     = {1'b0, o_x} + (HW+1)'(i_speed);
   assign w_hit_x  = i_speed != 4'd0 && (o_dir_x ? w_nx >= (HW+1)'(MAXX) : o_x <= HW'(i_speed));
   assign w_x_next = o_dir_x ? (w_hit_x ? HW'(MAXX) : w_nx[HW-1:0]) : (w_hit_x ? '0 : o_x - HW'(i_speed));
   assign w_ny     = {1'b0, o_y} + (VW+1)'(r_speed);
   assign w_hit_y  = r_speed != 4'd0 && (o_dir_y ? w_ny >= (VW+1)'(MAXY) : o_y <= VW'(r_speed));
   assign w_y_next = o_dir_y ? (w_hit_y ? VW'(MAXY) : w_ny[VW-1:0]) : (w_hit_y ? '0 : o_y - VW'(r_speed));
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state    <= IDLE;
         r_raw_q    <= 1'b0;
         r_speed    <= '0;
         o_x        <= HW'(START_X);
         o_y        <= VW'(START_Y);
         o_dir_x    <= 1'b1;
         o_dir_y    <= 1'b1;
         o_bounce_x <= 1'b0;
         o_bounce_y <= 1'b0;
         o_busy     <= 1'b0;
      end else begin
         r_raw_q    <= w_raw;
         o_bounce_x <= 1'b0;
         o_bounce_y <= 1'b0;
         case (r_state)
            IDLE: begin
               o_x     <= HW'(START_X);
               o_y     <= VW'(START_Y);
               o_dir_x <= 1'b1;
               o_dir_y <= 1'b1;
               if (i_enable) r_state <= RUN;
            end
            RUN: begin
               if (w_tick) begin
                  r_state <= UPD_X;
                  o_busy  <= 1'b1;
               end else if (!i_enable) begin
                  r_state <= PAUSE;
               end
            end
            UPD_X: begin
               r_speed    <= i_speed;
               o_x        <= w_x_next;
               o_dir_x    <= w_hit_x ? ~o_dir_x : o_dir_x;
               o_bounce_x <= w_hit_x;
               r_state    <= UPD_Y;
            end
            UPD_Y: begin
               o_y        <= w_y_next;
               o_dir_y    <= w_hit_y ? ~o_dir_y : o_dir_y;
               o_bounce_y <= w_hit_y;
               o_busy     <= 1'b0;
               r_state    <= RUN;
            end
            PAUSE: if (i_enable) r_state <= RUN;
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// tb_sprite_motion_ctrl: scoreboard bench running three start configurations side by side
module tb_sprite_motion_ctrl;
   localparam int HW = 10, VW = 10;
   localparam int MAXX = 512, MAXY = 352;
   typedef struct {
      string tag;
      int idx;
      int x;
      int y;
      bit dx;
      bit dy;
      int bxn;
      int byn;
      int busyn;
   } exp_t;
   logic clk = 1'b0, rst = 1'b1, en = 1'b0;
   logic [HW-1:0] hc = '0;
   logic [VW-1:0] vc = '0;
   logic [3:0] spd [3];
   logic [HW-1:0] ox [3];
   logic [VW-1:0] oy [3];
   logic odx [3], ody [3], obx [3], oby [3], obusy [3];
   int sx [3] = '{0, 508, 510};
   int sy [3] = '{0, 0, 350};
   int mx [3], my [3];
   bit mdx [3], mdy [3];
   exp_t sb [$];
   int checks = 0, errors = 0;
   always #5 clk = ~clk;
   for (genvar g = 0; g < 3; g++) begin : g_dut
      sprite_motion_ctrl #(
         .START_X(g == 0 ? 0 : (g == 1 ? 508 : 510)),
         .START_Y(g == 2 ? 350 : 0)
      ) u_dut (
         .i_clk(clk), .i_rst(rst), .i_hcount(hc), .i_vcount(vc), .i_enable(en), .i_speed(spd[g]),
         .o_x(ox[g]), .o_y(oy[g]), .o_dir_x(odx[g]), .o_dir_y(ody[g]),
         .o_bounce_x(obx[g]), .o_bounce_y(oby[g]), .o_busy(obusy[g])
      );
   end
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask
   function automatic void step(inout int p, inout bit d, input int s, input int lim, output bit b);
      b = 1'b0;
      if (s == 0) return;
      if (d) begin
         if (p + s >= lim) begin p = lim; d = 1'b0; b = 1'b1; end
         else p = p + s;
      end else begin
         if (p <= s) begin p = 0; d = 1'b1; b = 1'b1; end
         else p = p - s;
      end
   endfunction
   function automatic void model_reset();
      for (int i = 0; i < 3; i++) begin
         mx[i] = sx[i];
         my[i] = sy[i];
         mdx[i] = 1'b1;
         mdy[i] = 1'b1;
      end
      sb.delete();
   endfunction
   task automatic frame(input string tag, input int hold, input bit upd, input bit tmg, input bit drop);
      int bxn [3], byn [3], bsn [3], bxc [3], byc [3];
      int px0, py0;
      bit bx, by;
      exp_t e;
      px0 = mx[0];
      py0 = my[0];
      for (int i = 0; i < 3; i++) begin
         bx = 1'b0;
         by = 1'b0;
         if (upd) begin
            step(mx[i], mdx[i], int'(spd[i]), MAXX, bx);
            step(my[i], mdy[i], int'(spd[i]), MAXY, by);
         end
         sb.push_back('{tag, i, mx[i], my[i], mdx[i], mdy[i], int'(bx), int'(by), upd ? 2 : 0});
         bxn[i] = 0; byn[i] = 0; bsn[i] = 0; bxc[i] = -1; byc[i] = -1;
      end
      for (int c = 0; c < hold + 8; c++) begin
         @(negedge clk);
         for (int i = 0; i < 3; i++) begin
            if (obx[i]) begin bxn[i]++; bxc[i] = c; end
            if (oby[i]) begin byn[i]++; byc[i] = c; end
            if (obusy[i]) bsn[i]++;
         end
         if (tmg && c == 1) begin
            check({tag, "_busy_on"}, obusy[0], 1);
            check({tag, "_x_not_yet"}, ox[0], px0);
         end
         if (tmg && c == 2) begin
            check({tag, "_x_lat2"}, ox[0], mx[0]);
            check({tag, "_y_not_yet"}, oy[0], py0);
         end
         if (tmg && c == 3) begin
            check({tag, "_y_lat3"}, oy[0], my[0]);
            check({tag, "_busy_off"}, obusy[0], 0);
         end
         if (drop && c == 1) en = 1'b0;
         hc = c < hold ? 10'd640 : 10'd0;
         vc = c < hold ? 10'd480 : 10'd0;
      end
      while (sb.size() > 0) begin
         e = sb.pop_front();
         check({e.tag, "_x"}, ox[e.idx], e.x);
         check({e.tag, "_y"}, oy[e.idx], e.y);
         check({e.tag, "_dirx"}, odx[e.idx], e.dx);
         check({e.tag, "_diry"}, ody[e.idx], e.dy);
         check({e.tag, "_bouncex_cycles"}, bxn[e.idx], e.bxn);
         check({e.tag, "_bouncey_cycles"}, byn[e.idx], e.byn);
         check({e.tag, "_busy_cycles"}, bsn[e.idx], e.busyn);
      end
      if (bxn[2] == 1 && byn[2] == 1) check({tag, "_corner_order"}, byc[2], bxc[2] + 1);
   endtask
   task automatic check_start(input string tag);
      for (int i = 0; i < 3; i++) begin
         check({tag, "_x"}, ox[i], sx[i]);
         check({tag, "_y"}, oy[i], sy[i]);
         check({tag, "_dirx"}, odx[i], 1);
         check({tag, "_diry"}, ody[i], 1);
         check({tag, "_busy"}, obusy[i], 0);
         check({tag, "_bounce"}, {obx[i], oby[i]}, 0);
      end
   endtask
   initial begin
      spd = '{4'd4, 4'd5, 4'd3};
      model_reset();
      @(negedge clk);
      check_start("reset");
      @(negedge clk);
      rst = 1'b0;
      for (int f = 0; f < 3; f++) frame("idle", 3, 1'b0, 1'b0, 1'b0);
      en = 1'b1;
      repeat (2) @(negedge clk);
      frame("f1", 4, 1'b1, 1'b1, 1'b0);
      frame("f2", 2, 1'b1, 1'b0, 1'b0);
      frame("stall", 10, 1'b1, 1'b0, 1'b0);
      frame("drop", 4, 1'b1, 1'b0, 1'b1);
      frame("paused", 3, 1'b0, 1'b0, 1'b0);
      en = 1'b1;
      repeat (2) @(negedge clk);
      frame("resume", 3, 1'b1, 1'b0, 1'b0);
      spd = '{4'd0, 4'd0, 4'd0};
      frame("spd0", 3, 1'b1, 1'b0, 1'b0);
      spd = '{4'd4, 4'd5, 4'd3};
      @(negedge clk);
      hc = 10'd640;
      vc = 10'd480;
      @(posedge clk);
      #2 rst = 1'b1;
      #1 check_start("async_rst");
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      frame("post_rst", 3, 1'b0, 1'b0, 1'b0);
      frame("post_run", 3, 1'b1, 1'b0, 1'b0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
